// File: rtl/xadc_drp_sampler_pkg.sv
// xadc_drp_sampler_pkg: shared DRP widths, default channel addresses, sampler state type and saturating increment
package xadc_drp_sampler_pkg;
  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;
  localparam logic [DRP_AW-1:0] VOLTAGE_ADDR_DEF = 7'h03;
  localparam logic [DRP_AW-1:0] CURRENT_ADDR_DEF = 7'h1E;
  typedef enum logic [2:0] {
    IDLE,
    READ_V_REQ,
    READ_V_WAIT,
    READ_I_REQ,
    READ_I_WAIT,
    PRESENT
  } xadc_drp_sampler_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/xadc_drp_sampler_reader.sv
// xadc_drp_reader: one DRP read transaction (den pulse on start, wait for drdy or give up after TIMEOUT cycles)
// Ports: clk/rst; start_i+addr_i begin a read; den_o/daddr_o drive the DRP; do_i/drdy_i return data;
//        done_o pulses with data_o = 12-bit MSB-aligned sample shifted down; timeout_o pulses on abort.
module xadc_drp_reader
  import xadc_drp_sampler_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DRP_AW-1:0] addr_i,
  output logic              den_o,
  output logic [DRP_AW-1:0] daddr_o,
  input  logic [DRP_DW-1:0] do_i,
  input  logic              drdy_i,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DRP_DW-1:0] data_o
);
  localparam int TW = $clog2(TIMEOUT);
  logic              busy_q, busy_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DRP_AW-1:0] addr_q, addr_d;
  assign den_o     = start_i;
  assign daddr_o   = start_i ? addr_i : addr_q;
  assign done_o    = busy_q & drdy_i;
  assign timeout_o = busy_q & ~drdy_i & (timer_q == TW'(TIMEOUT - 1));
  assign data_o    = do_i >> 4;
  always_comb begin
    busy_d  = start_i | (busy_q & ~done_o & ~timeout_o);
    timer_d = start_i ? '0 : busy_q ? timer_q + TW'(1) : timer_q;
    addr_d  = start_i ? addr_i : addr_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy_q  <= 1'b0;
      timer_q <= '0;
      addr_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
    end
endmodule

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: per-EOS DRP read of voltage and current channels, presented as a paired pair of 16-bit AXI streams
// Ports: clk/rst; eos_i sequence pulse; drp_* DRP master; voltage_channel_* and current_monitor_channel_*
//        AXIS sources (tdata/tvalid/tready/tlast/tkeep); overrun_count_o and timeout_count_o saturating debug counters.
module xadc_drp_sampler
  import xadc_drp_sampler_pkg::*;
#(
  parameter logic [DRP_AW-1:0] VOLTAGE_ADDR = VOLTAGE_ADDR_DEF,
  parameter logic [DRP_AW-1:0] CURRENT_ADDR = CURRENT_ADDR_DEF,
  parameter int                DRP_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eos_i,
  output logic [DRP_AW-1:0] drp_daddr_o,
  output logic              drp_den_o,
  output logic              drp_dwe_o,
  output logic [DRP_DW-1:0] drp_di_o,
  input  logic [DRP_DW-1:0] drp_do_i,
  input  logic              drp_drdy_i,
  output logic [15:0]       voltage_channel_tdata_o,
  output logic              voltage_channel_tvalid_o,
  input  logic              voltage_channel_tready_i,
  output logic              voltage_channel_tlast_o,
  output logic [1:0]        voltage_channel_tkeep_o,
  output logic [15:0]       current_monitor_channel_tdata_o,
  output logic              current_monitor_channel_tvalid_o,
  input  logic              current_monitor_channel_tready_i,
  output logic              current_monitor_channel_tlast_o,
  output logic [1:0]        current_monitor_channel_tkeep_o,
  output logic [15:0]       overrun_count_o,
  output logic [15:0]       timeout_count_o
);
  xadc_drp_sampler_state_t state_q, state_d;
  logic [15:0]       v_q, v_d, i_q, i_d, ovr_q, tmo_q;
  logic              vv_q, vv_d, iv_q, iv_d;
  logic              rd_start, rd_done, rd_tmo;
  logic [DRP_DW-1:0] rd_data;
  logic [DRP_AW-1:0] rd_addr;
  assign rd_start = (state_q == READ_V_REQ) | (state_q == READ_I_REQ);
  assign rd_addr  = (state_q == READ_I_REQ) ? CURRENT_ADDR : VOLTAGE_ADDR;
  xadc_drp_reader #(.TIMEOUT(DRP_TIMEOUT)) u_reader (
    .clk      (clk),
    .rst      (rst),
    .start_i  (rd_start),
    .addr_i   (rd_addr),
    .den_o    (drp_den_o),
    .daddr_o  (drp_daddr_o),
    .do_i     (drp_do_i),
    .drdy_i   (drp_drdy_i),
    .done_o   (rd_done),
    .timeout_o(rd_tmo),
    .data_o   (rd_data)
  );
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    i_d     = i_q;
    vv_d    = vv_q;
    iv_d    = iv_q;
    case (state_q)
      IDLE:        state_d = eos_i ? READ_V_REQ : IDLE;
      READ_V_REQ:  state_d = READ_V_WAIT;
      READ_V_WAIT: begin
        v_d     = rd_done ? rd_data : rd_tmo ? '0 : v_q;
        state_d = rd_done ? READ_I_REQ : rd_tmo ? IDLE : READ_V_WAIT;
      end
      READ_I_REQ:  state_d = READ_I_WAIT;
      READ_I_WAIT: begin
        i_d     = rd_done ? rd_data : i_q;
        v_d     = rd_tmo ? '0 : v_q;
        vv_d    = rd_done;
        iv_d    = rd_done;
        state_d = rd_done ? PRESENT : rd_tmo ? IDLE : READ_I_WAIT;
      end
      PRESENT: begin
        vv_d    = vv_q & ~voltage_channel_tready_i;
        iv_d    = iv_q & ~current_monitor_channel_tready_i;
        state_d = (vv_d | iv_d) ? PRESENT : IDLE;
      end
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      i_q     <= '0;
      vv_q    <= 1'b0;
      iv_q    <= 1'b0;
      ovr_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      i_q     <= i_d;
      vv_q    <= vv_d;
      iv_q    <= iv_d;
      ovr_q   <= (eos_i && state_q != IDLE) ? sat_inc(ovr_q) : ovr_q;
      tmo_q   <= rd_tmo ? sat_inc(tmo_q) : tmo_q;
    end
  assign drp_dwe_o                        = 1'b0;
  assign drp_di_o                         = '0;
  assign voltage_channel_tdata_o          = v_q;
  assign voltage_channel_tvalid_o         = vv_q;
  assign voltage_channel_tlast_o          = 1'b0;
  assign voltage_channel_tkeep_o          = 2'b11;
  assign current_monitor_channel_tdata_o  = i_q;
  assign current_monitor_channel_tvalid_o = iv_q;
  assign current_monitor_channel_tlast_o  = 1'b0;
  assign current_monitor_channel_tkeep_o  = 2'b11;
  assign overrun_count_o                  = ovr_q;
  assign timeout_count_o                  = tmo_q;
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: directed and random stimulus against a transaction-timed reference model of the sampler
module tb_xadc_drp_sampler;
  localparam int TO = 64;
  localparam logic [6:0] VA = 7'h03;
  localparam logic [6:0] IA = 7'h1E;
  logic clk = 1'b0, rst = 1'b1, eos = 1'b0, drdy = 1'b0, vrdy = 1'b1, irdy = 1'b1;
  logic [15:0] drp_do = '0;
  logic [6:0] daddr;
  logic den, dwe, vtv, itv, vtl, itl;
  logic [15:0] di, vtd, itd, ovr, tmo;
  logic [1:0] vtk, itk;
  int cyc = 0, errors = 0, checks = 0, nv = 0, ni = 0;
  int drp_lat = 1;
  bit rand_data = 0;
  xadc_drp_sampler dut (
    .clk(clk), .rst(rst), .eos_i(eos),
    .drp_daddr_o(daddr), .drp_den_o(den), .drp_dwe_o(dwe), .drp_di_o(di),
    .drp_do_i(drp_do), .drp_drdy_i(drdy),
    .voltage_channel_tdata_o(vtd), .voltage_channel_tvalid_o(vtv),
    .voltage_channel_tready_i(vrdy), .voltage_channel_tlast_o(vtl), .voltage_channel_tkeep_o(vtk),
    .current_monitor_channel_tdata_o(itd), .current_monitor_channel_tvalid_o(itv),
    .current_monitor_channel_tready_i(irdy), .current_monitor_channel_tlast_o(itl),
    .current_monitor_channel_tkeep_o(itk),
    .overrun_count_o(ovr), .timeout_count_o(tmo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_eos();
    eos = 1'b1;
    tick();
    eos = 1'b0;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  // XADC DRP stand-in: answers each den after drp_lat cycles (0 = never answers)
  initial begin
    int due;
    logic [6:0] due_addr;
    due = -1;
    due_addr = '0;
    forever begin
      @(negedge clk);
      if (den && drp_lat > 0) begin
        due = cyc + drp_lat;
        due_addr = daddr;
      end
      @(posedge clk);
      #1;
      drdy = (cyc == due);
      drp_do = (cyc != due || rand_data) ? 16'($urandom) : (due_addr == VA ? 16'hABC0 : 16'h1230);
    end
  end
  // Reference model: events are timestamped in cycles from the rules (den one cycle after a
  // trigger, data one cycle after drdy, abort when TO cycles pass since den).
  bit m_busy = 0, m_vp = 0, m_ip = 0, nb;
  int m_den_at = -1, m_den_cyc = -1, m_rd = 0, m_next = 0;
  logic [6:0] m_addr = '0;
  logic [15:0] m_v = '0, m_i = '0, m_ov = '0, m_to = '0;
  always @(negedge clk) if (cyc >= 1) begin
    if (m_den_at == cyc) m_addr = (m_next == 1) ? VA : IA;
    if (vtv && vrdy) nv++;
    if (itv && irdy) ni++;
    check("den", den, m_den_at == cyc);
    check("daddr", daddr, m_addr);
    check("dwe", dwe, 0);
    check("di", di, 0);
    check("v_tvalid", vtv, m_vp);
    check("i_tvalid", itv, m_ip);
    if (m_vp) check("v_tdata", vtd, m_v);
    if (m_ip) check("i_tdata", itd, m_i);
    check("overrun", ovr, m_ov);
    check("timeout", tmo, m_to);
    check("tlast", {vtl, itl}, 0);
    check("tkeep", {vtk, itk}, 4'hF);
    if (rst) begin
      m_busy = 0; m_den_at = -1; m_rd = 0; m_vp = 0; m_ip = 0;
      m_ov = '0; m_to = '0; m_addr = '0;
    end else begin
      nb = m_busy;
      if (eos) begin
        if (!m_busy) begin
          nb = 1; m_den_at = cyc + 1; m_next = 1;
        end else m_ov = (m_ov == 16'hFFFF) ? m_ov : m_ov + 16'd1;
      end
      if (m_den_at == cyc) begin
        m_rd = m_next; m_den_cyc = cyc;
      end else if (m_rd != 0) begin
        if (drdy) begin
          if (m_rd == 1) begin
            m_v = drp_do >> 4; m_den_at = cyc + 1; m_next = 2;
          end else begin
            m_i = drp_do >> 4; m_vp = 1; m_ip = 1;
          end
          m_rd = 0;
        end else if (cyc - m_den_cyc == TO) begin
          m_to = (m_to == 16'hFFFF) ? m_to : m_to + 16'd1;
          m_rd = 0; nb = 0;
        end
      end else if (m_vp || m_ip) begin
        if (vrdy) m_vp = 0;
        if (irdy) m_ip = 0;
        if (!m_vp && !m_ip) nb = 0;
      end
      m_busy = nb;
    end
  end
  initial begin
    int p;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_overrun", ovr, 0);
    check("rst_tvalid", {vtv, itv}, 0);
    check("rst_daddr", daddr, 0);
    check("rst_den", den, 0);
    // basic pair, tvalid exactly 5 cycles after eos
    pulse_eos();
    tick(3);
    check("lat_v_early", vtv, 0);
    tick();
    check("lat_v", vtv, 1);
    check("lat_i", itv, 1);
    check("lit_v_data", vtd, 16'h0ABC);
    check("lit_i_data", itd, 16'h0123);
    tick();
    check("one_xfer", {vtv, itv}, 0);
    check("pair_count", nv * 100 + ni, 101);
    // voltage back-pressure; eos during the stall is an overrun
    vrdy = 1'b0;
    pulse_eos();
    tick(4);
    tick();
    check("bp_i_done", itv, 0);
    check("bp_v_held", vtv, 1);
    pulse_eos();
    tick(7);
    check("bp_v_data", vtd, 16'h0ABC);
    vrdy = 1'b1;
    tick();
    check("bp_v_done", vtv, 0);
    check("bp_overrun", ovr, 1);
    pulse_eos();
    tick(6);
    check("bp_next_pair", nv * 100 + ni, 303);
    // three overruns during one sequence, the last coinciding with completion
    reset_dut();
    p = nv;
    pulse_eos();
    eos = 1'b1; tick(); eos = 1'b0; tick();
    eos = 1'b1; tick(); eos = 1'b0; tick();
    eos = 1'b1; tick(); eos = 1'b0;
    tick(3);
    check("ovr3", ovr, 3);
    check("ovr3_pairs", nv - p, 1);
    // DRP never answers
    reset_dut();
    drp_lat = 0;
    p = nv;
    pulse_eos();
    tick(64);
    check("tmo_before", tmo, 0);
    tick();
    check("tmo_after", tmo, 1);
    tick(5);
    check("tmo_no_out", nv - p, 0);
    drp_lat = 1;
    pulse_eos();
    tick(6);
    check("tmo_recover", nv - p, 1);
    // reset while waiting on the current-channel read, late drdy afterwards
    reset_dut();
    drp_lat = 8;
    p = nv;
    pulse_eos();
    tick(11);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    check("rst_mid_out", nv - p, 0);
    check("rst_mid_cnt", {ovr, tmo}, 0);
    drp_lat = 1;
    pulse_eos();
    tick(4);
    check("rst_mid_v", vtd, 16'h0ABC);
    check("rst_mid_i", itd, 16'h0123);
    tick(2);
    // random traffic
    rand_data = 1;
    for (int k = 0; k < 3000; k++) begin
      eos = ($urandom_range(0, 7) == 0);
      vrdy = 1'($urandom);
      irdy = 1'($urandom);
      drp_lat = ($urandom_range(0, 40) == 0) ? 0 : int'($urandom_range(1, 5));
      tick();
    end
    eos = 1'b0; vrdy = 1'b1; irdy = 1'b1; drp_lat = 1;
    tick(80);
    // overrun counter saturation
    rand_data = 0;
    reset_dut();
    vrdy = 1'b0; irdy = 1'b0;
    pulse_eos();
    tick(5);
    eos = 1'b1;
    tick(65540);
    eos = 1'b0;
    tick();
    check("ovr_sat", ovr, 16'hFFFF);
    vrdy = 1'b1; irdy = 1'b1;
    tick(3);
    check("ovr_sat_hold", ovr, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
